fpnew_hub_lane_sequencer: RTL

FPNEW_HUB_LANE_SEQUENCER -- requirements
Module: fpnew_hub_lane_sequencer

---
 rtl/fpnew_hub_lane_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fpnew_hub_lane_sequencer.sv
// Lane sequencer: time-multiplexes one scalar HUB add/mul/div unit across the
// lanes of a packed SIMD request, keeping exactly one lane outstanding at a time.

package fpnew_pkg;
  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;
endpackage

module fpnew_hub_lane_sequencer #(
  parameter int Width    = 64,
  parameter int FpWidth  = 16,
  parameter int TagWidth = 4,
  localparam int NumLanes = Width / FpWidth,
  localparam int LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2*Width-1:0]     operands_i,   // {B, A}
  input  fpnew_pkg::operation_e  op_i,
  input  logic                   op_mod_i,
  input  logic                   vectorial_op_i,
  input  logic [NumLanes-1:0]    simd_mask_i,
  input  logic [TagWidth-1:0]    tag_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   flush_i,
  output logic [Width-1:0]       result_o,
  output fpnew_pkg::status_t     status_o,
  output logic [TagWidth-1:0]    tag_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   busy_o,
  output logic [2*FpWidth-1:0]   unit_operands_o, // {B lane, A lane}
  output fpnew_pkg::operation_e  unit_op_o,
  output logic                   unit_op_mod_o,
  output logic                   unit_valid_o,
  input  logic                   unit_ready_i,
  input  logic [FpWidth-1:0]     unit_result_i,
  input  fpnew_pkg::status_t     unit_status_i,
  input  logic                   unit_out_valid_i,
  output logic                   unit_out_ready_o,
  output logic                   unit_flush_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e state, state_next;

  logic [Width-1:0]      opa_q, opb_q, result_q, init_result;
  fpnew_pkg::operation_e op_q;
  logic                  op_mod_q;
  logic [TagWidth-1:0]   tag_q;
  fpnew_pkg::status_t    status_q;
  logic [NumLanes-1:0]   pending_q;  // active lanes still to be issued/completed
  logic [NumLanes-1:0]   accept_lanes, remaining;
  logic [LaneW-1:0]      lane;
  logic                  accept, unit_done;

  function automatic logic [LaneW-1:0] lowest_lane(input logic [NumLanes-1:0] m);
    lowest_lane = '0;
    for (int i = NumLanes - 1; i >= 0; i--)
      if (m[i]) lowest_lane = LaneW'(i);
  endfunction

  assign lane         = lowest_lane(pending_q);
  assign remaining    = pending_q & ~(NumLanes'(1) << lane);
  assign accept_lanes = vectorial_op_i ? simd_mask_i : NumLanes'(1);

  // A flush blocks acceptance, so upstream never sees a handshake that is dropped.
  assign in_ready_o = ~rst_i & ~flush_i &
                      ((state == IDLE) | ((state == DONE) & out_ready_i));
  assign accept     = in_valid_i & in_ready_o;
  assign unit_done  = (state == WAIT) & unit_out_valid_i;

  // Seed the buffer with the pass-through values; active lanes get overwritten.
  always_comb begin
    init_result = '1;
    if (vectorial_op_i) init_result = operands_i[Width-1:0];
    else                init_result[FpWidth-1:0] = operands_i[FpWidth-1:0];
  end

  // NOTE: default assignment first so every path drives state_next (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (accept) state_next = (accept_lanes == '0) ? DONE : ISSUE;
      ISSUE: if (unit_ready_i) state_next = WAIT;
      WAIT:  if (unit_out_valid_i) state_next = (remaining == '0) ? DONE : ISSUE;
      DONE:  if (out_ready_i)
               state_next = !accept ? IDLE : ((accept_lanes == '0) ? DONE : ISSUE);
      default: state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      op_q      <= fpnew_pkg::FMADD;
      op_mod_q  <= 1'b0;
      tag_q     <= '0;
      status_q  <= '0;
      pending_q <= '0;
    end else if (flush_i) begin
      result_q  <= '0;
      status_q  <= '0;
      pending_q <= '0;
    end else if (accept) begin
      opa_q     <= operands_i[Width-1:0];
      opb_q     <= operands_i[2*Width-1:Width];
      op_q      <= op_i;
      op_mod_q  <= op_mod_i;
      tag_q     <= tag_i;
      status_q  <= '0;
      result_q  <= init_result;
      pending_q <= accept_lanes;
    end else if (unit_done) begin
      result_q[lane*FpWidth +: FpWidth] <= unit_result_i;
      status_q  <= fpnew_pkg::status_t'(status_q | unit_status_i);
      pending_q <= remaining;
    end
  end

  assign unit_operands_o  = {opb_q[lane*FpWidth +: FpWidth], opa_q[lane*FpWidth +: FpWidth]};
  assign unit_op_o        = op_q;
  assign unit_op_mod_o    = op_mod_q;
  assign unit_valid_o     = (state == ISSUE);
  assign unit_out_ready_o = (state == WAIT);
  assign unit_flush_o     = flush_i;

  assign out_valid_o = (state == DONE);
  assign busy_o      = (state != IDLE);
  assign result_o    = result_q;
  assign status_o    = status_q;
  assign tag_o       = tag_q;

endmodule
